// File: rtl/dla_sched_pkg.sv
// Shared types and default parameters for the DLA tile scheduler.
// The state enum and default sizes are common to the top, lane counters and interface.
package dla_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_LANES   = 12;
    localparam int DEF_TILE_WORDS  = 64;
    localparam int DEF_DRAIN_WORDS = 32;
    localparam int DEF_TILE_CNT_W  = 16;
    localparam int DEF_WDOG_CYCLES = 4096;

endpackage

// File: rtl/dla_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and the DDR lanes / compute array.
// The scheduler is the master: it issues ready, compute launch and the drain window.
interface dla_sched_if
    import dla_sched_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES
);

    logic [NUM_LANES-1:0] i_lane_valid;
    logic [NUM_LANES-1:0] o_lane_ready;
    logic                 o_compute_start;
    logic                 i_compute_done;
    logic                 o_drain_en;
    logic                 i_drain_valid;

    modport master (
        input  i_lane_valid,
        input  i_compute_done,
        input  i_drain_valid,
        output o_lane_ready,
        output o_compute_start,
        output o_drain_en
    );

    modport slave (
        output i_lane_valid,
        output i_compute_done,
        output i_drain_valid,
        input  o_lane_ready,
        input  o_compute_start,
        input  o_drain_en
    );

endinterface

// File: rtl/dla_lane_counter.sv
// Per-lane beat counter for one DDR input stream: counts accepted beats up to
// TILE_WORDS and drives a registered ready that drops the cycle after the last beat.
module dla_lane_counter
    import dla_sched_pkg::*;
#(
    parameter int TILE_WORDS = DEF_TILE_WORDS
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic load_next,
    input  logic valid,
    output logic ready,
    output logic full
);

    localparam int CNT_W = $clog2(TILE_WORDS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ready_d;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no latch is inferred.
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (valid && ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Ready looks at the post-update count, so a lane never over-accepts.
        ready_d = load_next && (cnt_d < CNT_W'(TILE_WORDS));
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_reset_n) begin
            cnt_q <= '0;
            ready <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ready <= ready_d;
        end
    end

    assign full = (cnt_q == CNT_W'(TILE_WORDS));

endmodule

// File: rtl/dla_tile_scheduler.sv
// Tile sequencer: LOAD lane beats, launch COMPUTE, DRAIN results, repeat per tile.
// Optional compute watchdog under `define DLA_SCHED_WATCHDOG_EN.
module dla_tile_scheduler
    import dla_sched_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int TILE_WORDS  = DEF_TILE_WORDS,
    parameter int DRAIN_WORDS = DEF_DRAIN_WORDS,
    parameter int TILE_CNT_W  = DEF_TILE_CNT_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [TILE_CNT_W-1:0] i_num_tiles,
    dla_sched_if.master           bus,
    output logic [TILE_CNT_W-1:0] o_tile_idx,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int DRAIN_CNT_W = $clog2(DRAIN_WORDS + 1);

    sched_state_e            state_q;
    sched_state_e            state_d;
    logic [TILE_CNT_W-1:0]   num_tiles_q;
    logic [TILE_CNT_W-1:0]   tile_idx_q;
    logic [DRAIN_CNT_W-1:0]  drain_cnt_q;
    logic [NUM_LANES-1:0]    lane_full;
    logic [NUM_LANES-1:0]    lane_ready;
    logic                    lane_clear;
    logic                    lane_load_next;
    logic                    all_full;
    logic                    start_acc;
    logic                    abort_act;
    logic                    drain_beat;
    logic                    last_beat;
    logic                    last_tile;
    logic                    timeout;
    logic                    tile_done;
    logic                    all_done_d;
    logic                    compute_start_q;
    logic                    drain_en_q;
    logic                    done_q;

    assign start_acc  = (state_q == ST_IDLE) && i_start && !i_abort;
    assign abort_act  = (state_q != ST_IDLE) && i_abort;
    assign all_full   = &lane_full;
    assign drain_beat = drain_en_q && bus.i_drain_valid;
    assign last_beat  = drain_beat && (drain_cnt_q == DRAIN_CNT_W'(DRAIN_WORDS - 1));
    assign last_tile  = (tile_idx_q + TILE_CNT_W'(1)) == num_tiles_q;

    always_comb begin
        state_d    = state_q;
        tile_done  = 1'b0;
        all_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    if (i_num_tiles == '0) all_done_d = 1'b1;
                    else                   state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (all_full) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (bus.i_compute_done) state_d = ST_DRAIN;
                else if (timeout)       state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (last_beat) begin
                    tile_done = 1'b1;
                    if (last_tile) begin
                        state_d    = ST_IDLE;
                        all_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every other outcome of this cycle.
        if (abort_act) begin
            state_d    = ST_IDLE;
            tile_done  = 1'b0;
            all_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q         <= ST_IDLE;
            num_tiles_q     <= '0;
            tile_idx_q      <= '0;
            drain_cnt_q     <= '0;
            compute_start_q <= 1'b0;
            drain_en_q      <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            compute_start_q <= (state_q == ST_LOAD) && (state_d == ST_COMPUTE);
            drain_en_q      <= (state_d == ST_DRAIN);
            done_q          <= all_done_d;
            drain_cnt_q     <= (state_d == ST_DRAIN) ? drain_cnt_q + DRAIN_CNT_W'(drain_beat) : '0;
            if (start_acc) begin
                num_tiles_q <= i_num_tiles;
                tile_idx_q  <= '0;
            end else if (abort_act) begin
                tile_idx_q <= '0;
            end else if (tile_done && !last_tile) begin
                tile_idx_q <= tile_idx_q + TILE_CNT_W'(1);
            end
        end
    end

`ifdef DLA_SCHED_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              error_q;

    // Counter is 0 on the o_compute_start cycle, so the last allowed cycle is WDOG_CYCLES-1.
    assign timeout = (state_q == ST_COMPUTE) && !bus.i_compute_done &&
                     (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wdog_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if ((state_q == ST_COMPUTE) && (state_d == ST_COMPUTE)) wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
            else                                                     wdog_cnt_q <= '0;
            if (start_acc)                   error_q <= 1'b0;
            else if (timeout && !abort_act)  error_q <= 1'b1;
        end
    end

    assign o_error = error_q;
`else
    logic wdog_unused;

    assign timeout     = 1'b0;
    assign wdog_unused = ^WDOG_CYCLES;
    assign o_error     = 1'b0;
`endif

    assign lane_clear     = (state_d == ST_IDLE) || ((state_q == ST_DRAIN) && (state_d == ST_LOAD));
    assign lane_load_next = (state_d == ST_LOAD);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        dla_lane_counter #(
            .TILE_WORDS (TILE_WORDS)
        ) u_lane_counter (
            .clk       (clk),
            .i_reset_n (i_reset_n),
            .clear     (lane_clear),
            .load_next (lane_load_next),
            .valid     (bus.i_lane_valid[k]),
            .ready     (lane_ready[k]),
            .full      (lane_full[k])
        );
    end

    assign bus.o_lane_ready    = lane_ready;
    assign bus.o_compute_start = compute_start_q;
    assign bus.o_drain_en      = drain_en_q;
    assign o_tile_idx          = tile_idx_q;
    assign o_busy              = (state_q != ST_IDLE);
    // o_valid must coincide with the final drain beat, hence it is combinational.
    assign o_valid             = tile_done;
    assign o_done              = done_q;

endmodule

// File: tb/tb_dla_tile_scheduler.sv
// Directed self-checking bench for dla_tile_scheduler (default 12 lanes x 64 beats, 32 drain beats).
// Watchdog scenario is included when DLA_SCHED_WATCHDOG_EN is defined.
module tb_dla_tile_scheduler;
    import dla_sched_pkg::*;

    localparam int NL = 12;
    localparam int TW = 64;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [CW-1:0] i_num_tiles = '0;
    logic [NL-1:0] lane_valid = '0;
    logic [CW-1:0] o_tile_idx;
    logic          o_busy, o_valid, o_done, o_error;

    int checks = 0;
    int failures = 0;

    dla_sched_if #(.NUM_LANES(NL)) bus();
    assign bus.i_lane_valid = lane_valid;

    always #5 clk = ~clk;

    dla_tile_scheduler #(
        .NUM_LANES(NL), .TILE_WORDS(TW), .DRAIN_WORDS(DW), .TILE_CNT_W(CW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_num_tiles(i_num_tiles), .bus(bus), .o_tile_idx(o_tile_idx), .o_busy(o_busy),
        .o_valid(o_valid), .o_done(o_done), .o_error(o_error)
    );

    // Event monitor, sampled mid-cycle.
    int n_xfer [NL];
    int lane_sum = 0, n_drain = 0, n_valid = 0, n_done = 0, n_cstart = 0;
    int drain_mark = 0, cs_lane7 = 0;
    int vq_idx[$];
    int vq_beats[$];
    int cs_sum[$];

    initial for (int k = 0; k < NL; k++) n_xfer[k] = 0;

    always @(negedge clk) begin
        if (i_reset_n) begin
            for (int k = 0; k < NL; k++) begin
                if (lane_valid[k] && bus.o_lane_ready[k]) begin
                    n_xfer[k]++;
                    lane_sum++;
                end
            end
            if (bus.o_drain_en && bus.i_drain_valid) n_drain++;
            if (o_valid) begin
                n_valid++;
                vq_idx.push_back(int'(o_tile_idx));
                vq_beats.push_back(n_drain - drain_mark);
                drain_mark = n_drain;
            end
            if (o_done) n_done++;
            if (bus.o_compute_start) begin
                n_cstart++;
                cs_sum.push_back(lane_sum);
                cs_lane7 = n_xfer[7];
            end
        end
    end

    // Compute-array model: i_compute_done cd_delay cycles after o_compute_start (0 = same cycle).
    bit cd_auto = 1'b1;
    int cd_delay = 5;
    int cd_timer = 0;

    initial begin
        bus.i_compute_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_compute_done = 1'b0;
            if (cd_timer > 0) begin
                cd_timer--;
                if (cd_timer == 0) bus.i_compute_done = 1'b1;
            end
            if (bus.o_compute_start && cd_auto) begin
                if (cd_delay == 0) bus.i_compute_done = 1'b1;
                else               cd_timer = cd_delay;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        i_num_tiles = CW'(n);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int base = n_done;
        int c = 0;
        while (n_done == base && c < budget) begin
            tick();
            c++;
        end
        checks++;
        if (n_done == base) begin
            failures++;
            $display("FAIL %s_timeout: o_done not seen within %0d cycles", name, budget);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_valid, o_error, bus.o_compute_start, bus.o_drain_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {o_busy, o_done, o_valid, o_error, bus.o_compute_start, bus.o_drain_en});
        end
        checks++;
        if (bus.o_lane_ready !== '0) begin failures++; $display("FAIL reset_ready: got %h expected 0", bus.o_lane_ready); end
        checks++;
        if (o_tile_idx !== '0) begin failures++; $display("FAIL reset_tile_idx: got %0d expected 0", o_tile_idx); end
        i_reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_two_tiles();
        int b_cs = n_cstart, b_v = n_valid, b_d = n_done, b_dr = n_drain, b_sum = lane_sum;
        int b_vq = vq_idx.size(), b_cq = cs_sum.size();
        int b_x [NL];
        int bad = 0;
        b_x = n_xfer;
        lane_valid = '1;
        bus.i_drain_valid = 1'b1;
        cd_auto = 1'b1;
        cd_delay = 5;
        start_run(2);
        checks++;
        if (bus.o_lane_ready !== {NL{1'b1}}) begin failures++; $display("FAIL two_first_ready: got %h expected fff", bus.o_lane_ready); end
        wait_done("two_tiles", 1000);
        checks++;
        if (n_cstart - b_cs != 2) begin failures++; $display("FAIL two_cstart: got %0d expected 2", n_cstart - b_cs); end
        checks++;
        if (n_valid - b_v != 2) begin failures++; $display("FAIL two_valid: got %0d expected 2", n_valid - b_v); end
        checks++;
        if (n_done - b_d != 1) begin failures++; $display("FAIL two_done: got %0d expected 1", n_done - b_d); end
        for (int k = 0; k < NL; k++) if (n_xfer[k] - b_x[k] != 2 * TW) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL two_lane_beats: lanes off=%0d expected 0", bad); end
        checks++;
        if (cs_sum[b_cq] - b_sum != NL * TW) begin
            failures++; $display("FAIL two_tile0_load: got %0d expected %0d", cs_sum[b_cq] - b_sum, NL * TW);
        end
        checks++;
        if (cs_sum[b_cq + 1] - cs_sum[b_cq] != NL * TW) begin
            failures++; $display("FAIL two_tile1_load: got %0d expected %0d", cs_sum[b_cq + 1] - cs_sum[b_cq], NL * TW);
        end
        checks++;
        if (n_drain - b_dr != 2 * DW) begin failures++; $display("FAIL two_drain_total: got %0d expected %0d", n_drain - b_dr, 2 * DW); end
        checks++;
        if (vq_beats[b_vq] != DW || vq_beats[b_vq + 1] != DW) begin
            failures++; $display("FAIL two_drain_per_tile: got %0d,%0d expected 32,32", vq_beats[b_vq], vq_beats[b_vq + 1]);
        end
        checks++;
        if (vq_idx[b_vq] != 0 || vq_idx[b_vq + 1] != 1) begin
            failures++; $display("FAIL two_tile_idx: got %0d,%0d expected 0,1", vq_idx[b_vq], vq_idx[b_vq + 1]);
        end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL two_idle_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_lane_stall();
        int b_cs = n_cstart;
        int b_x [NL];
        int bad = 0;
        b_x = n_xfer;
        lane_valid = '1;
        lane_valid[7] = 1'b0;
        start_run(1);
        repeat (20) tick();
        lane_valid[7] = 1'b1;
        repeat (50) tick();
        for (int k = 0; k < NL; k++) if (k != 7 && n_xfer[k] - b_x[k] != TW) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_other_lanes: lanes off=%0d expected 0", bad); end
        checks++;
        if (bus.o_lane_ready !== 12'h080) begin failures++; $display("FAIL stall_ready: got %h expected 080", bus.o_lane_ready); end
        checks++;
        if (n_xfer[7] - b_x[7] != 50) begin failures++; $display("FAIL stall_lane7: got %0d expected 50", n_xfer[7] - b_x[7]); end
        checks++;
        if (n_cstart != b_cs) begin failures++; $display("FAIL stall_early_cstart: got %0d expected 0", n_cstart - b_cs); end
        wait_done("lane_stall", 1000);
        checks++;
        if (cs_lane7 - b_x[7] != TW) begin failures++; $display("FAIL stall_lane7_at_cstart: got %0d expected 64", cs_lane7 - b_x[7]); end
        checks++;
        if (n_xfer[7] - b_x[7] != TW) begin failures++; $display("FAIL stall_lane7_total: got %0d expected 64", n_xfer[7] - b_x[7]); end
    endtask

    task automatic test_zero_tiles();
        int b_d = n_done;
        start_run(0);
        checks++;
        if (o_done !== 1'b1) begin failures++; $display("FAIL zero_done_pulse: got %b expected 1", o_done); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b expected 0", o_busy); end
        checks++;
        if (bus.o_lane_ready !== '0) begin failures++; $display("FAIL zero_ready: got %h expected 0", bus.o_lane_ready); end
        tick();
        checks++;
        if ({o_done, o_busy} !== 2'b00) begin failures++; $display("FAIL zero_after: done,busy=%b expected 00", {o_done, o_busy}); end
        checks++;
        if (n_done - b_d != 1) begin failures++; $display("FAIL zero_done_count: got %0d expected 1", n_done - b_d); end
    endtask

    task automatic test_abort_drain();
        int b_v = n_valid, b_d = n_done, b_vq;
        int c = 0;
        lane_valid = '1;
        bus.i_drain_valid = 1'b1;
        cd_delay = 5;
        start_run(2);
        while (!bus.o_drain_en && c < 500) begin
            tick();
            c++;
        end
        checks++;
        if (bus.o_drain_en !== 1'b1) begin failures++; $display("FAIL abort_reach_drain: drain_en=%b expected 1", bus.o_drain_en); end
        repeat (DW - 1) tick();
        i_abort = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b expected 0", o_valid); end
        tick();
        i_abort = 1'b0;
        checks++;
        if ({o_busy, bus.o_drain_en, o_done} !== 3'b000) begin
            failures++; $display("FAIL abort_idle: busy,drain_en,done=%b expected 000", {o_busy, bus.o_drain_en, o_done});
        end
        checks++;
        if (bus.o_lane_ready !== '0) begin failures++; $display("FAIL abort_ready: got %h expected 0", bus.o_lane_ready); end
        tick();
        checks++;
        if (n_valid != b_v || n_done != b_d) begin
            failures++; $display("FAIL abort_pulses: valid=%0d done=%0d expected 0,0", n_valid - b_v, n_done - b_d);
        end
        b_v = n_valid;
        b_vq = vq_idx.size();
        start_run(2);
        checks++;
        if (o_tile_idx !== '0) begin failures++; $display("FAIL abort_restart_idx: got %0d expected 0", o_tile_idx); end
        wait_done("abort_restart", 1000);
        checks++;
        if (n_valid - b_v != 2 || vq_idx[b_vq] != 0) begin
            failures++; $display("FAIL abort_restart_run: valid=%0d first_idx=%0d expected 2,0", n_valid - b_v, vq_idx[b_vq]);
        end
    endtask

    task automatic test_start_ignored();
        int b_v = n_valid, b_cs = n_cstart, b_d = n_done, b_vq = vq_idx.size();
        lane_valid = '1;
        start_run(3);
        repeat (10) tick();
        i_num_tiles = CW'(5);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if ({o_busy, o_tile_idx} !== {1'b1, CW'(0)}) begin
            failures++; $display("FAIL ignore_start_state: busy=%b idx=%0d expected 1,0", o_busy, o_tile_idx);
        end
        wait_done("start_ignored", 1500);
        checks++;
        if (n_valid - b_v != 3 || n_cstart - b_cs != 3 || n_done - b_d != 1) begin
            failures++; $display("FAIL ignore_counts: valid=%0d cstart=%0d done=%0d expected 3,3,1",
                                 n_valid - b_v, n_cstart - b_cs, n_done - b_d);
        end
        checks++;
        if (vq_idx[b_vq] != 0 || vq_idx[b_vq + 1] != 1 || vq_idx[b_vq + 2] != 2) begin
            failures++; $display("FAIL ignore_idx_seq: got %0d,%0d,%0d expected 0,1,2",
                                 vq_idx[b_vq], vq_idx[b_vq + 1], vq_idx[b_vq + 2]);
        end
    endtask

    task automatic test_done_same_cycle();
        int b_v = n_valid, b_cs = n_cstart;
        cd_delay = 0;
        start_run(1);
        wait_done("done_same_cycle", 500);
        checks++;
        if (n_valid - b_v != 1 || n_cstart - b_cs != 1) begin
            failures++; $display("FAIL same_cycle_done: valid=%0d cstart=%0d expected 1,1", n_valid - b_v, n_cstart - b_cs);
        end
        cd_delay = 5;
    endtask

`ifdef DLA_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int b_d = n_done;
        int c = 0;
        cd_auto = 1'b0;
        lane_valid = '1;
        start_run(1);
        while (!bus.o_compute_start && c < 500) begin
            tick();
            c++;
        end
        checks++;
        if (bus.o_compute_start !== 1'b1) begin failures++; $display("FAIL wdog_cstart: got %b expected 1", bus.o_compute_start); end
        repeat (WD - 1) tick();
        checks++;
        if ({o_error, o_busy} !== 2'b01) begin failures++; $display("FAIL wdog_before: error,busy=%b expected 01", {o_error, o_busy}); end
        tick();
        checks++;
        if ({o_error, o_busy, o_done} !== 3'b100) begin
            failures++; $display("FAIL wdog_fire: error,busy,done=%b expected 100", {o_error, o_busy, o_done});
        end
        tick();
        checks++;
        if (n_done != b_d || o_error !== 1'b1) begin
            failures++; $display("FAIL wdog_sticky: done=%0d error=%b expected 0,1", n_done - b_d, o_error);
        end
        cd_auto = 1'b1;
        start_run(1);
        checks++;
        if (o_error !== 1'b0) begin failures++; $display("FAIL wdog_clear: got %b expected 0", o_error); end
        wait_done("wdog_recover", 500);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.i_drain_valid = 1'b0;
        test_reset();
        test_two_tiles();
        test_lane_stall();
        test_zero_tiles();
        test_abort_drain();
        test_start_ignored();
        test_done_same_cycle();
`ifdef DLA_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
